// File: rtl/vq_pkg.sv
// Shared widths and state type for the VQ compress/decompress datapaths.
// No logic; constants and types only.
// Both the compress side and vq_decode_unit import this so the index and pixel widths stay in lockstep.
package vq_pkg;

    localparam int PIX_W   = 8;                      // pixel width in bits
    localparam int VEC_LEN = 16;                     // pixels per codeword (4x4 block)
    localparam int CB_SIZE = 8;                      // codebook entries
    localparam int IDX_W   = $clog2(CB_SIZE);        // codebook index width
    localparam int POS_W   = $clog2(VEC_LEN);        // element position width
    localparam int ADDR_W  = IDX_W + POS_W;          // flat {entry, element} address
    localparam int CB_DEPTH = CB_SIZE * VEC_LEN;     // total stored elements

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } vq_state_t;

endpackage

// File: rtl/vq_codebook_regs.sv
// Codebook storage: CB_SIZE x VEC_LEN pixel registers, one write port, one async read port.
// Latency: write lands at the next clk edge; read is combinational from raddr.
// Backpressure: none; the caller gates we (writes are simply not issued while busy).
// Ports: clk/rst (sync, active-high, clears every element), we/waddr/wdata write port,
//        raddr/rdata read port, both addressed as {entry, element}.
module vq_codebook_regs
    import vq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [CB_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CB_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Address space is exactly CB_DEPTH because both dimensions are powers of two.
    assign rdata = mem[raddr];

endmodule

// File: rtl/vq_decode_unit.sv
// VQ decoder: expands each codebook index into VEC_LEN pixels, one per pix handshake.
// Latency: index accepted at edge N gives first pixel in cycle N+1; back-to-back vectors have no bubble.
// Backpressure: pix_ready low stalls the element counter; idx_ready in EMIT is pix_ready & pix_last (no skid).
// Ports: clk/rst (sync, active-high); cb_we/cb_waddr/cb_wdata codebook load, cb_drop pulses when a
//        write arrives while busy; idx_valid/idx_ready/idx_data index input; pix_valid/pix_ready/
//        pix_data/pix_pos/pix_last pixel output; busy high while a vector is being emitted.
module vq_decode_unit
    import vq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cb_we,
    input  logic [ADDR_W-1:0] cb_waddr,
    input  logic [PIX_W-1:0]  cb_wdata,
    output logic              cb_drop,
    input  logic              idx_valid,
    output logic              idx_ready,
    input  logic [IDX_W-1:0]  idx_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic [POS_W-1:0]  pix_pos,
    output logic              pix_last,
    output logic              busy
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(VEC_LEN - 1);

    vq_state_t        state;
    logic [IDX_W-1:0] idx_reg;
    logic [POS_W-1:0] cnt;
    logic             emitting;
    logic             cb_wr_en;

    assign emitting = (state == EMIT);

    // Codebook is frozen while a vector is in flight so a vector never mixes old and new data.
    assign cb_wr_en = cb_we & ~emitting;

    vq_codebook_regs u_cb (
        .clk   (clk),
        .rst   (rst),
        .we    (cb_wr_en),
        .waddr (cb_waddr),
        .wdata (cb_wdata),
        .raddr ({idx_reg, cnt}),
        .rdata (pix_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx_reg <= '0;
            cnt     <= '0;
            cb_drop <= 1'b0;
        end else begin
            cb_drop <= cb_we & emitting;
            case (state)
                IDLE: begin
                    if (idx_valid) begin
                        idx_reg <= idx_data;
                        cnt     <= '0;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (pix_ready) begin
                        if (cnt == LAST_POS) begin
                            cnt <= '0;
                            // A waiting index chains straight into the next vector.
                            if (idx_valid) begin
                                idx_reg <= idx_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign pix_valid = emitting;
    assign busy      = emitting;
    assign pix_pos   = cnt;
    assign pix_last  = emitting & (cnt == LAST_POS);
    assign idx_ready = ~emitting | (pix_ready & pix_last);

endmodule
